// File: rtl/multi_edge_sync_cnt.sv
// Multi-channel async level synchroniser with edge capture and pending-event counters.
// Optional per-channel deglitch filter enabled by defining EDGE_SYNC_DEGLITCH_EN.
module multi_edge_sync_cnt #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3,
  parameter int EDGE_MODE   = 0,
  parameter int GLITCH_CYC  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       async_in,
  output logic [N_CH-1:0]       sync_level,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*CNT_W-1:0] out_count,
  output logic [N_CH-1:0]       overflow,
  input  logic [N_CH-1:0]       ovf_clr
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  if (N_CH < 1 || SYNC_STAGES < 2 || GLITCH_CYC < 1 ||
      EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_cfg
    $error("multi_edge_sync_cnt: illegal parameter set");
  end

  logic [N_CH-1:0] stage_q [SYNC_STAGES];
  logic [N_CH-1:0] raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        stage_q[k] <= '0;
    end else begin
      stage_q[0] <= async_in;
      for (int k = 1; k < SYNC_STAGES; k++)
        stage_q[k] <= stage_q[k-1];
    end
  end

  assign raw = stage_q[SYNC_STAGES-1];

`ifdef EDGE_SYNC_DEGLITCH_EN
  localparam int GW = $clog2(GLITCH_CYC + 1);
  localparam logic [GW-1:0] RUN_LAST = GW'(GLITCH_CYC - 1);

  logic [N_CH-1:0] filt_q;
  logic [GW-1:0]   run_q [N_CH];

  // Filtered level follows raw only after GLITCH_CYC consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < N_CH; i++)
        run_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (raw[i] != filt_q[i]) begin
          if (run_q[i] == RUN_LAST) begin
            filt_q[i] <= raw[i];
            run_q[i]  <= '0;
          end else begin
            run_q[i] <= run_q[i] + 1'b1;
          end
        end else begin
          run_q[i] <= '0;
        end
      end
    end
  end

  assign sync_level = filt_q;
`else
  assign sync_level = raw;
`endif

  logic [N_CH-1:0] hist_q;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] evt;
  logic [N_CH-1:0] pop;

  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= sync_level;
  end

  assign rise = sync_level & ~hist_q;
  assign fall = ~sync_level & hist_q;
  assign evt  = (EDGE_MODE == 0) ? rise :
                (EDGE_MODE == 1) ? fall : (rise | fall);

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [N_CH-1:0]  ovf_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign out_valid[i]                  = |cnt_q[i];
    assign out_count[i*CNT_W +: CNT_W]   = cnt_q[i];
  end

  assign pop      = out_valid & out_ready;
  assign overflow = ovf_q;

  // Simultaneous event and pop cancel, so a full counter never overflows then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= '0;
      for (int i = 0; i < N_CH; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        case ({evt[i], pop[i]})
          2'b10: begin
            if (cnt_q[i] != CMAX)
              cnt_q[i] <= cnt_q[i] + 1'b1;
          end
          2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
        if (evt[i] && !pop[i] && cnt_q[i] == CMAX)
          ovf_q[i] <= 1'b1;
        else if (ovf_clr[i])
          ovf_q[i] <= 1'b0;
      end
    end
  end

endmodule
